// File: rtl/poly_addsub_seq_if.sv
// rtl/poly_addsub_seq_if.sv - handshake and coefficient-RAM bus of the polynomial add/sub sequencer
//
// Signals (directions seen from the sequencer, i.e. the slave modport):
//   start_i, op_i, abort_i     controller request, 0 = add / 1 = subtract, cancel
//   busy_o, done_o, err_o      status, one-cycle completion pulse, sticky range error
//   rd_en_o, rd_addr_o         read strobe and shared address for source RAMs A and B
//   a_data_i, b_data_i         source coefficients, valid one cycle after rd_en_o
//   wr_en_o, wr_addr_o,
//   wr_data_o                  destination RAM write port
interface poly_addsub_seq_if #(
    parameter int ADDR_W = 8
);
    logic              start_i;
    logic              op_i;
    logic              abort_i;
    logic              busy_o;
    logic              done_o;
    logic              err_o;
    logic              rd_en_o;
    logic [ADDR_W-1:0] rd_addr_o;
    logic [11:0]       a_data_i;
    logic [11:0]       b_data_i;
    logic              wr_en_o;
    logic [ADDR_W-1:0] wr_addr_o;
    logic [11:0]       wr_data_o;

    modport slave (
        input  start_i, op_i, abort_i, a_data_i, b_data_i,
        output busy_o, done_o, err_o, rd_en_o, rd_addr_o,
               wr_en_o, wr_addr_o, wr_data_o
    );

    modport master (
        output start_i, op_i, abort_i, a_data_i, b_data_i,
        input  busy_o, done_o, err_o, rd_en_o, rd_addr_o,
               wr_en_o, wr_addr_o, wr_data_o
    );
endinterface

// File: rtl/poly_addsub_seq.sv
// rtl/poly_addsub_seq.sv - streams one polynomial through a mod-3329 adder/subtractor
//
// Ports:
//   clk     system clock, rising edge
//   rst_n   asynchronous active-low reset
//   bus     poly_addsub_seq_if.slave: start/op/abort in, busy/done/err out,
//           source RAM read port (rd_en_o/rd_addr_o, a_data_i/b_data_i),
//           destination RAM write port (wr_en_o/wr_addr_o/wr_data_o)
//
// Pipeline: stage 0 issues read k, stage 1 sees the RAM data and computes the
// modular result, which is registered straight into the write-port registers
// (stage 2). Start-to-done latency is N_COEFF+3 cycles.
module poly_addsub_seq #(
    parameter int N_COEFF = 256,
    parameter int ADDR_W  = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    poly_addsub_seq_if.slave    bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [12:0]       Q       = 13'd3329;
    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(N_COEFF - 1);

    logic [1:0]        state_q,   state_d;
    logic              op_q,      op_d;
    logic              rd_en_q,   rd_en_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic              dv_q,      dv_d;       // RAM data valid this cycle
    logic [ADDR_W-1:0] addr1_q,   addr1_d;    // address belonging to that data
    logic              wr_en_q,   wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [11:0]       wr_data_q, wr_data_d;
    logic              err_q,     err_d;
    logic              done_q,    done_d;
    logic              busy_q,    busy_d;

    logic              start_ok;
    logic              abort_ok;
    logic              range_bad;
    logic [12:0]       sum;
    logic [12:0]       diff;
    logic [12:0]       res13;

    // Modular add/sub on the returning RAM data. Subtract relies on the
    // 13-bit wrap: a negative difference plus Q lands back in 0..3328.
    always_comb begin
        sum       = {1'b0, bus.a_data_i} + {1'b0, bus.b_data_i};
        diff      = {1'b0, bus.a_data_i} - {1'b0, bus.b_data_i};
        res13     = sum;
        if (op_q) begin
            res13 = diff[12] ? (diff + Q) : diff;
        end else begin
            res13 = (sum >= Q) ? (sum - Q) : sum;
        end
        range_bad = ({1'b0, bus.a_data_i} >= Q) || ({1'b0, bus.b_data_i} >= Q);
    end

    always_comb begin
        start_ok  = bus.start_i && ((state_q == S_IDLE) || (state_q == S_DONE));
        abort_ok  = bus.abort_i && busy_q;

        state_d   = state_q;
        op_d      = op_q;
        rd_en_d   = 1'b0;
        rd_addr_d = rd_addr_q;
        dv_d      = rd_en_q;
        addr1_d   = rd_addr_q;
        wr_en_d   = dv_q;
        wr_addr_d = dv_q ? addr1_q : wr_addr_q;
        wr_data_d = dv_q ? res13[11:0] : wr_data_q;
        err_d     = err_q | (dv_q & range_bad);
        done_d    = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_ok) begin
                    state_d   = S_RUN;
                    op_d      = bus.op_i;
                    err_d     = 1'b0;
                    rd_en_d   = 1'b1;
                    rd_addr_d = '0;
                end else begin
                    state_d   = S_IDLE;
                end
            end
            S_RUN: begin
                // rd_addr_q is the address being issued this cycle
                rd_addr_d = rd_addr_q + ADDR_W'(1);
                if (rd_addr_q == LAST) begin
                    state_d = S_DRAIN;
                end else begin
                    rd_en_d = 1'b1;
                end
            end
            S_DRAIN: begin
                if (wr_en_q && (wr_addr_q == LAST)) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort flushes every in-flight strobe; the sticky error survives.
        if (abort_ok) begin
            state_d = S_IDLE;
            rd_en_d = 1'b0;
            dv_d    = 1'b0;
            wr_en_d = 1'b0;
            done_d  = 1'b0;
            err_d   = err_q;
        end

        busy_d = (state_d == S_RUN) || (state_d == S_DRAIN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            op_q      <= 1'b0;
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
            dv_q      <= 1'b0;
            addr1_q   <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            err_q     <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            rd_en_q   <= rd_en_d;
            rd_addr_q <= rd_addr_d;
            dv_q      <= dv_d;
            addr1_q   <= addr1_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            err_q     <= err_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
        end
    end

    assign bus.busy_o    = busy_q;
    assign bus.done_o    = done_q;
    assign bus.err_o     = err_q;
    assign bus.rd_en_o   = rd_en_q;
    assign bus.rd_addr_o = rd_addr_q;
    assign bus.wr_en_o   = wr_en_q;
    assign bus.wr_addr_o = wr_addr_q;
    assign bus.wr_data_o = wr_data_q;
endmodule

// File: tb/tb_poly_addsub_seq.sv
// tb/tb_poly_addsub_seq.sv - self-checking bench for poly_addsub_seq
module tb_poly_addsub_seq;
    localparam int N = 256;
    localparam int Q = 3329;

    typedef struct {
        logic op;
        int   a_kind;   // 0 ramp k, 1 constant, 2 random in range, 3 ramp with A[17]=a_val
        int   a_val;
        int   b_kind;
        int   b_val;
        bit   exp_err;
    } vec_t;

    typedef struct {
        int addr;
        int data;
        bit dc;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    exp_t sbq[$];
    logic [11:0] mem_a [N];
    logic [11:0] mem_b [N];
    logic [11:0] dst   [N];
    vec_t vecs [7];

    poly_addsub_seq_if #(.ADDR_W(8)) bus ();

    poly_addsub_seq #(.N_COEFF(N), .ADDR_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Source RAMs: synchronous read, data one cycle after the strobe
    always @(posedge clk) begin
        if (bus.rd_en_o === 1'b1) begin
            bus.a_data_i <= mem_a[bus.rd_addr_o];
            bus.b_data_i <= mem_b[bus.rd_addr_o];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Scoreboard consumer: every write is compared against the queue head
    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus.wr_en_o === 1'b1) begin
            dst[bus.wr_addr_o] = bus.wr_data_o;
            if (sbq.size() == 0) begin
                chk("unexpected_write_addr", 32'(bus.wr_addr_o), 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("wr_addr", 32'(bus.wr_addr_o), 32'(e.addr));
                if (!e.dc) chk("wr_data", 32'(bus.wr_data_o), 32'(e.data));
            end
        end
    end

    function automatic int gen(input int kind, input int val, input int k);
        case (kind)
            0:       return k;
            1:       return val;
            2:       return int'($urandom_range(Q - 1));
            default: return (k == 17) ? val : k;
        endcase
    endfunction

    task automatic fill(input vec_t v);
        for (int k = 0; k < N; k++) begin
            mem_a[k] = 12'(gen(v.a_kind, v.a_val, k));
            mem_b[k] = 12'(gen(v.b_kind, v.b_val, k));
        end
    endtask

    task automatic push_expected(input logic op);
        for (int k = 0; k < N; k++) begin
            exp_t e;
            int a, b;
            a = int'(mem_a[k]);
            b = int'(mem_b[k]);
            e.addr = k;
            e.dc   = (a >= Q) || (b >= Q);
            e.data = op ? ((a - b + Q) % Q) : ((a + b) % Q);
            sbq.push_back(e);
        end
    endtask

    task automatic kick(input logic op);
        @(negedge clk);
        bus.start_i = 1'b1;
        bus.op_i    = op;
        push_expected(op);
        @(posedge clk);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_busy"},    32'(bus.busy_o),    0);
        chk({tag, "_done"},    32'(bus.done_o),    0);
        chk({tag, "_err"},     32'(bus.err_o),     0);
        chk({tag, "_rd_en"},   32'(bus.rd_en_o),   0);
        chk({tag, "_rd_addr"}, 32'(bus.rd_addr_o), 0);
        chk({tag, "_wr_en"},   32'(bus.wr_en_o),   0);
        chk({tag, "_wr_addr"}, 32'(bus.wr_addr_o), 0);
        chk({tag, "_wr_data"}, 32'(bus.wr_data_o), 0);
    endtask

    // Follows one accepted operation cycle by cycle (cycle 1 = after the start edge)
    task automatic run_body(input logic op, input bit exp_err, input bit chain, input logic next_op);
        int bad_rd = 0, bad_ra = 0, bad_wr = 0, bad_wa = 0, bad_busy = 0, bad_done = 0;
        int done_cyc = -1;
        for (int c = 1; c <= N + 3; c++) begin
            logic exp_rd, exp_wr, exp_busy, exp_done;
            @(negedge clk);
            exp_rd   = (c >= 1) && (c <= N);
            exp_wr   = (c >= 3) && (c <= N + 2);
            exp_busy = (c >= 1) && (c <= N + 2);
            exp_done = (c == N + 3);
            if (c == 1) begin
                bus.start_i = 1'b0;
                chk("err_clear_on_start", 32'(bus.err_o), 0);
            end
            if (bus.rd_en_o !== exp_rd) bad_rd++;
            if (bus.rd_en_o === 1'b1 && int'(bus.rd_addr_o) != c - 1) bad_ra++;
            if (bus.wr_en_o !== exp_wr) bad_wr++;
            if (bus.wr_en_o === 1'b1 && int'(bus.wr_addr_o) != c - 3) bad_wa++;
            if (bus.busy_o !== exp_busy) bad_busy++;
            if (bus.done_o !== exp_done) bad_done++;
            if (bus.done_o === 1'b1 && done_cyc < 0) done_cyc = c;
            if (c == 18) chk("err_before_bad_coeff", 32'(bus.err_o), 0);
            if (exp_err && c == 20) chk("err_raised", 32'(bus.err_o), 1);
            // start pulses while busy (RUN and DRAIN) with the opposite op must be ignored
            if (c == 50 || c == N + 1) begin
                bus.start_i = 1'b1;
                bus.op_i    = ~op;
            end
            if (c == 51 || c == N + 2) bus.start_i = 1'b0;
            if (c == N + 3) begin
                chk("err_at_done", 32'(bus.err_o), 32'(exp_err));
                chk("all_writes_seen", 32'(sbq.size()), 0);
                chk("done_cycle", 32'(done_cyc), N + 3);
                if (chain) begin
                    bus.start_i = 1'b1;
                    bus.op_i    = next_op;
                    push_expected(next_op);
                end
            end
        end
        chk("rd_en_window", 32'(bad_rd), 0);
        chk("rd_addr_seq", 32'(bad_ra), 0);
        chk("wr_en_window", 32'(bad_wr), 0);
        chk("wr_addr_seq", 32'(bad_wa), 0);
        chk("busy_window", 32'(bad_busy), 0);
        chk("done_pulse", 32'(bad_done), 0);
    endtask

    initial begin
        int bad;
        checks = 0;
        errors = 0;
        vecs[0] = '{op: 1'b0, a_kind: 0, a_val: 0,    b_kind: 1, b_val: 3328, exp_err: 1'b0};
        vecs[1] = '{op: 1'b1, a_kind: 1, a_val: 0,    b_kind: 1, b_val: 1,    exp_err: 1'b0};
        vecs[2] = '{op: 1'b1, a_kind: 1, a_val: 3328, b_kind: 1, b_val: 3328, exp_err: 1'b0};
        vecs[3] = '{op: 1'b0, a_kind: 2, a_val: 0,    b_kind: 2, b_val: 0,    exp_err: 1'b0};
        vecs[4] = '{op: 1'b1, a_kind: 2, a_val: 0,    b_kind: 2, b_val: 0,    exp_err: 1'b0};
        vecs[5] = '{op: 1'b0, a_kind: 3, a_val: 4000, b_kind: 1, b_val: 5,    exp_err: 1'b1};
        vecs[6] = '{op: 1'b1, a_kind: 2, a_val: 0,    b_kind: 1, b_val: 0,    exp_err: 1'b0};

        rst_n        = 1'b0;
        bus.start_i  = 1'b0;
        bus.op_i     = 1'b0;
        bus.abort_i  = 1'b0;
        bus.a_data_i = '0;
        bus.b_data_i = '0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;

        // abort outside busy is ignored
        @(negedge clk);
        bus.abort_i = 1'b1;
        @(negedge clk);
        bus.abort_i = 1'b0;
        chk("idle_abort_no_busy", 32'(bus.busy_o), 0);

        for (int i = 0; i < 7; i++) begin
            fill(vecs[i]);
            kick(vecs[i].op);
            run_body(vecs[i].op, vecs[i].exp_err, 1'b0, 1'b0);
            if (i == 0) begin
                chk("add_k0", 32'(dst[0]), 3328);
                chk("add_k1", 32'(dst[1]), 0);
                chk("add_k200", 32'(dst[200]), 199);
            end
            if (i == 1) chk("sub_underflow", 32'(dst[100]), 3328);
            if (i == 2) chk("sub_equal", 32'(dst[9]), 0);
        end

        // back-to-back: start in the done cycle, add then subtract on the same data
        fill(vecs[3]);
        kick(1'b0);
        run_body(1'b0, 1'b0, 1'b1, 1'b1);
        run_body(1'b1, 1'b0, 1'b0, 1'b0);

        // abort at cycle 100, asserted together with start: abort wins
        fill(vecs[0]);
        kick(1'b0);
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            if (c == 1) bus.start_i = 1'b0;
            if (c == 100) begin
                bus.abort_i = 1'b1;
                bus.start_i = 1'b1;
            end
        end
        @(negedge clk);
        bus.abort_i = 1'b0;
        bus.start_i = 1'b0;
        chk("abort_busy", 32'(bus.busy_o), 0);
        chk("abort_rd_en", 32'(bus.rd_en_o), 0);
        chk("abort_wr_en", 32'(bus.wr_en_o), 0);
        chk("abort_done", 32'(bus.done_o), 0);
        bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (bus.busy_o !== 1'b0 || bus.done_o !== 1'b0 || bus.rd_en_o !== 1'b0 || bus.wr_en_o !== 1'b0) bad++;
        end
        chk("abort_stays_idle", 32'(bad), 0);
        sbq.delete();
        kick(1'b0);
        run_body(1'b0, 1'b0, 1'b0, 1'b0);

        // asynchronous reset at cycle 50
        fill(vecs[4]);
        kick(1'b1);
        for (int c = 1; c <= 50; c++) begin
            @(negedge clk);
            if (c == 1) bus.start_i = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        check_zero("async_reset");
        bad = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus.wr_en_o !== 1'b0 || bus.busy_o !== 1'b0 || bus.done_o !== 1'b0) bad++;
        end
        chk("reset_hold_quiet", 32'(bad), 0);
        rst_n = 1'b1;
        sbq.delete();
        kick(1'b1);
        run_body(1'b1, 1'b0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
